// File: rtl/frame_sequencer_if.sv
// Host/Frame_State bundle for frame_sequencer: run configuration, FIFO level,
// frame handshake and host-visible status.
interface frame_sequencer_if;
  logic [31:0] cfg_length;
  logic [31:0] cfg_delay;
  logic [15:0] cfg_frames;
  logic [15:0] cfg_gap;
  logic        start;
  logic        abort;
  logic [15:0] fifo_byte_level;
  logic        frame_active;
  logic [31:0] reg_length;
  logic [31:0] reg_delay;
  logic        frame_go;
  logic        busy;
  logic        done;
  logic [2:0]  seq_state;
  logic [15:0] frames_done;
  logic        underrun;
  logic        ack_fault;
  logic        cfg_error;

  modport master (
    output cfg_length, cfg_delay, cfg_frames, cfg_gap, start, abort, fifo_byte_level,
           frame_active,
    input  reg_length, reg_delay, frame_go, busy, done, seq_state, frames_done, underrun,
           ack_fault, cfg_error
  );

  modport slave (
    input  cfg_length, cfg_delay, cfg_frames, cfg_gap, start, abort, fifo_byte_level,
           frame_active,
    output reg_length, reg_delay, frame_go, busy, done, seq_state, frames_done, underrun,
           ack_fault, cfg_error
  );
endinterface

// File: rtl/frame_sequencer.sv
// Run-level controller for the Frame_State DAC engine: shadows geometry, gates each
// launch on FIFO fill, sequences N (or endless) frames with an idle gap, reports faults.
module frame_sequencer #(
  parameter int unsigned WAIT_TIMEOUT = 1024,
  parameter int unsigned ACK_TIMEOUT  = 16
) (
  input  logic              ti_clk,
  input  logic              rst_n,
  frame_sequencer_if.slave  bus
);

  localparam logic [15:0] WaitLast = 16'(WAIT_TIMEOUT - 1);
  localparam logic [15:0] AckLast  = 16'(ACK_TIMEOUT - 1);

  typedef enum logic [2:0] {
    StIdle     = 3'd0,
    StArm      = 3'd1,
    StWaitData = 3'd2,
    StLaunch   = 3'd3,
    StRun      = 3'd4,
    StGap      = 3'd5,
    StDone     = 3'd6
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] len_q, len_d, dly_q, dly_d;
  logic [15:0] frames_q, frames_d, gap_q, gap_d;
  logic [63:0] need_q, need_d;
  logic [15:0] timer_q, timer_d;
  logic [15:0] frames_done_q, frames_done_d;
  logic        underrun_q, underrun_d, ack_fault_q, ack_fault_d, cfg_error_q, cfg_error_d;
  logic        abort_pend_q, abort_pend_d;
  logic        active_q;
  logic        frame_fall;
  logic [15:0] frames_inc;

  assign frame_fall = active_q & ~bus.frame_active;
  assign frames_inc = frames_done_q + 16'd1;

  always_comb begin
    state_d       = state_q;
    len_d         = len_q;
    dly_d         = dly_q;
    frames_d      = frames_q;
    gap_d         = gap_q;
    need_d        = need_q;
    timer_d       = timer_q;
    frames_done_d = frames_done_q;
    underrun_d    = underrun_q;
    ack_fault_d   = ack_fault_q;
    cfg_error_d   = cfg_error_q;
    abort_pend_d  = abort_pend_q;
    case (state_q)
      StIdle: begin
        if (bus.start && !bus.abort) begin
          if (bus.cfg_length == '0 || bus.cfg_delay == '0) begin
            cfg_error_d = 1'b1;
          end else begin
            len_d         = bus.cfg_length;
            dly_d         = bus.cfg_delay;
            frames_d      = bus.cfg_frames;
            gap_d         = bus.cfg_gap;
            frames_done_d = '0;
            underrun_d    = 1'b0;
            ack_fault_d   = 1'b0;
            cfg_error_d   = 1'b0;
            abort_pend_d  = 1'b0;
            timer_d       = '0;
            state_d       = StArm;
          end
        end
      end
      StArm: begin
        need_d  = {32'd0, len_q} * {32'd0, dly_q};
        timer_d = '0;
        state_d = bus.abort ? StDone : StWaitData;
      end
      StWaitData: begin
        if (bus.abort) begin
          state_d = StDone;
        end else if ({48'd0, bus.fifo_byte_level} >= need_q) begin
          timer_d = '0;
          state_d = StLaunch;
        end else if (timer_q == WaitLast) begin
          underrun_d = 1'b1;
          state_d    = StDone;
        end else begin
          timer_d = timer_q + 16'd1;
        end
      end
      StLaunch: begin
        // Abort here must not cut a frame the DAC may already be starting.
        if (bus.abort) abort_pend_d = 1'b1;
        if (bus.frame_active) begin
          state_d = StRun;
        end else if (timer_q == AckLast) begin
          ack_fault_d = 1'b1;
          state_d     = StDone;
        end else begin
          timer_d = timer_q + 16'd1;
        end
      end
      StRun: begin
        if (bus.abort) abort_pend_d = 1'b1;
        if (frame_fall) begin
          frames_done_d = frames_inc;
          timer_d       = '0;
          if (abort_pend_q || bus.abort || (frames_q != '0 && frames_inc == frames_q)) begin
            state_d = StDone;
          end else if (gap_q == '0) begin
            state_d = StWaitData;
          end else begin
            state_d = StGap;
          end
        end
      end
      StGap: begin
        if (bus.abort) begin
          state_d = StDone;
        end else if (timer_q == gap_q - 16'd1) begin
          timer_d = '0;
          state_d = StWaitData;
        end else begin
          timer_d = timer_q + 16'd1;
        end
      end
      StDone: begin
        abort_pend_d = 1'b0;
        state_d      = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge ti_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= StIdle;
      len_q         <= '0;
      dly_q         <= '0;
      frames_q      <= '0;
      gap_q         <= '0;
      need_q        <= '0;
      timer_q       <= '0;
      frames_done_q <= '0;
      underrun_q    <= 1'b0;
      ack_fault_q   <= 1'b0;
      cfg_error_q   <= 1'b0;
      abort_pend_q  <= 1'b0;
      active_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      len_q         <= len_d;
      dly_q         <= dly_d;
      frames_q      <= frames_d;
      gap_q         <= gap_d;
      need_q        <= need_d;
      timer_q       <= timer_d;
      frames_done_q <= frames_done_d;
      underrun_q    <= underrun_d;
      ack_fault_q   <= ack_fault_d;
      cfg_error_q   <= cfg_error_d;
      abort_pend_q  <= abort_pend_d;
      active_q      <= bus.frame_active;
    end
  end

  // frame_go decodes from state so an asynchronous reset drops it immediately.
  assign bus.frame_go    = (state_q == StLaunch) && (timer_q == '0);
  assign bus.busy        = (state_q != StIdle);
  assign bus.done        = (state_q == StDone);
  assign bus.seq_state   = state_q;
  assign bus.reg_length  = len_q;
  assign bus.reg_delay   = dly_q;
  assign bus.frames_done = frames_done_q;
  assign bus.underrun    = underrun_q;
  assign bus.ack_fault   = ack_fault_q;
  assign bus.cfg_error   = cfg_error_q;

endmodule

// File: tb/tb_frame_sequencer.sv
// Self-checking bench for frame_sequencer: Frame_State responder model plus a done-pulse
// scoreboard holding the expected end-of-run status of each accepted start.
module tb_frame_sequencer;

  typedef struct packed {
    logic [15:0] frames_done;
    logic        underrun;
    logic        ack_fault;
    logic        cfg_error;
  } exp_t;

  logic ti_clk = 1'b0;
  logic rst_n  = 1'b0;
  frame_sequencer_if bus();

  frame_sequencer dut (
    .ti_clk (ti_clk),
    .rst_n  (rst_n),
    .bus    (bus)
  );

  always #5 ti_clk = ~ti_clk;

  int   total = 0;
  int   bad   = 0;
  exp_t sb_q[$];

  int   cyc = 0, go_cnt = 0, done_cnt = 0, go_cyc = 0, fall_cyc = 0, go_gap = 0;
  int   ack_cyc = 0, act_cnt = 0;
  logic ack_prev = 1'b0;
  logic resp_en  = 1'b1;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Monitor and Frame_State model; outputs sampled on the falling edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge ti_clk);
      cyc++;
      if (bus.frame_go) begin
        go_cnt++;
        go_cyc = cyc;
        go_gap = cyc - fall_cyc;
      end
      if (bus.ack_fault && !ack_prev) ack_cyc = cyc;
      ack_prev = bus.ack_fault;
      if (bus.done) begin
        done_cnt++;
        check_eq("sb_nonempty", 64'(sb_q.size() != 0), 1);
        if (sb_q.size() != 0) begin
          e = sb_q.pop_front();
          check_eq("sb_frames_done", bus.frames_done, e.frames_done);
          check_eq("sb_underrun", bus.underrun, e.underrun);
          check_eq("sb_ack_fault", bus.ack_fault, e.ack_fault);
          check_eq("sb_cfg_error", bus.cfg_error, e.cfg_error);
        end
      end
      if (act_cnt > 0) begin
        bus.frame_active = 1'b1;
        act_cnt--;
      end else begin
        if (bus.frame_active) fall_cyc = cyc;
        bus.frame_active = 1'b0;
      end
      if (bus.frame_go && resp_en) act_cnt = 24;
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge ti_clk);
      #1;
    end
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    tick(1);
    bus.start = 1'b0;
  endtask

  task automatic pulse_abort();
    bus.abort = 1'b1;
    tick(1);
    bus.abort = 1'b0;
  endtask

  task automatic set_cfg(input int len, input int dly, input int frames, input int gap);
    bus.cfg_length = 32'(len);
    bus.cfg_delay  = 32'(dly);
    bus.cfg_frames = 16'(frames);
    bus.cfg_gap    = 16'(gap);
  endtask

  task automatic push_exp(input int fd, input logic ur, input logic af);
    exp_t e;
    e.frames_done = 16'(fd);
    e.underrun    = ur;
    e.ack_fault   = af;
    e.cfg_error   = 1'b0;
    sb_q.push_back(e);
  endtask

  task automatic wait_done(input string tag, input int bound);
    int d0 = done_cnt;
    for (int i = 0; i < bound && done_cnt == d0; i++) tick(1);
    check_eq(tag, 64'(done_cnt != d0), 1);
    tick(1);
  endtask

  task automatic wait_go(input string tag, input int target, input int bound);
    for (int i = 0; i < bound && go_cnt < target; i++) tick(1);
    check_eq(tag, 64'(go_cnt >= target), 1);
  endtask

  initial begin
    int g0, d0;
    set_cfg(0, 0, 0, 0);
    bus.start           = 1'b0;
    bus.abort           = 1'b0;
    bus.fifo_byte_level = '0;
    bus.frame_active    = 1'b0;

    // Reset state
    tick(3);
    check_eq("rst_busy", bus.busy, 0);
    check_eq("rst_state", bus.seq_state, 0);
    check_eq("rst_outputs", {bus.frame_go, bus.done, bus.underrun, bus.ack_fault,
                             bus.cfg_error}, 0);
    check_eq("rst_regs", {bus.reg_length, bus.reg_delay, bus.frames_done}, 0);
    rst_n = 1'b1;
    tick(2);

    // Start together with abort: abort wins
    set_cfg(8, 3, 1, 0);
    bus.start = 1'b1;
    bus.abort = 1'b1;
    tick(1);
    bus.start = 1'b0;
    bus.abort = 1'b0;
    check_eq("start_abort_busy", bus.busy, 0);

    // 1: two frames with a 4-cycle gap
    g0 = go_cnt;
    d0 = done_cnt;
    set_cfg(8, 3, 2, 4);
    bus.fifo_byte_level = 16'd30;
    push_exp(2, 1'b0, 1'b0);
    pulse_start();
    check_eq("t1_busy", bus.busy, 1);
    wait_done("t1_done", 400);
    check_eq("t1_go_count", go_cnt - g0, 2);
    check_eq("t1_go_gap", go_gap, 6);
    check_eq("t1_frames_done", bus.frames_done, 2);
    check_eq("t1_done_count", done_cnt - d0, 1);
    check_eq("t1_busy_after", bus.busy, 0);
    check_eq("t1_reg_length", bus.reg_length, 8);
    check_eq("t1_reg_delay", bus.reg_delay, 3);

    // 2: one byte short of a frame times out, then refill launches
    g0 = go_cnt;
    set_cfg(8, 3, 1, 0);
    bus.fifo_byte_level = 16'd23;
    push_exp(0, 1'b1, 1'b0);
    pulse_start();
    wait_done("t2_done", 1200);
    check_eq("t2_no_go", go_cnt - g0, 0);
    check_eq("t2_underrun", bus.underrun, 1);
    bus.fifo_byte_level = 16'd24;
    push_exp(1, 1'b0, 1'b0);
    pulse_start();
    check_eq("t2_underrun_clr", bus.underrun, 0);
    wait_done("t2_done2", 200);
    check_eq("t2_go", go_cnt - g0, 1);

    // 3: zero delay is rejected without a run
    set_cfg(8, 0, 1, 0);
    pulse_start();
    check_eq("t3_cfg_error", bus.cfg_error, 1);
    tick(2);
    check_eq("t3_busy", bus.busy, 0);
    set_cfg(8, 3, 1, 0);
    bus.fifo_byte_level = 16'd30;
    push_exp(1, 1'b0, 1'b0);
    pulse_start();
    check_eq("t3_cfg_error_clr", bus.cfg_error, 0);
    wait_done("t3_done", 200);

    // 4: continuous mode ended by an abort mid-frame
    g0 = go_cnt;
    set_cfg(8, 3, 0, 2);
    push_exp(2, 1'b0, 1'b0);
    pulse_start();
    wait_go("t4_second_go", g0 + 2, 300);
    tick(10);
    check_eq("t4_active", bus.frame_active, 1);
    pulse_abort();
    wait_done("t4_done", 200);
    tick(60);
    check_eq("t4_go_count", go_cnt - g0, 2);
    check_eq("t4_idle", bus.busy, 0);

    // 5: no acknowledge from Frame_State
    resp_en = 1'b0;
    set_cfg(8, 3, 1, 0);
    push_exp(0, 1'b0, 1'b1);
    pulse_start();
    wait_done("t5_done", 200);
    check_eq("t5_ack_latency", ack_cyc - go_cyc, 16);
    check_eq("t5_state", bus.seq_state, 0);
    resp_en = 1'b1;

    // 6: config change mid-run, then reset mid-run
    g0 = go_cnt;
    set_cfg(8, 3, 0, 0);
    pulse_start();
    wait_go("t6_go", g0 + 1, 100);
    tick(5);
    bus.cfg_length = 32'd100;
    tick(2);
    check_eq("t6_reg_length_held", bus.reg_length, 8);
    check_eq("t6_in_run", bus.seq_state, 4);
    #2 rst_n = 1'b0;
    #1;
    check_eq("t6_rst_busy", {bus.busy, bus.frame_go, bus.done}, 0);
    check_eq("t6_rst_regs", {bus.reg_length, bus.frames_done, 13'd0, bus.seq_state}, 0);
    tick(3);
    rst_n = 1'b1;
    tick(30);
    set_cfg(4, 3, 1, 0);
    push_exp(1, 1'b0, 1'b0);
    pulse_start();
    check_eq("t6_reg_length_new", bus.reg_length, 4);
    wait_done("t6_done", 200);

    check_eq("sb_drained", sb_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/frame_sequencer.md
Name: frame_sequencer

Overview:
- Run-level controller for the Frame_State DAC frame engine.
- Latches a frame geometry (bytes × columns) and holds Frame_State's reg_length and reg_delay constant for the whole run.
- Before each frame, gates the launch on enough bytes being present in the frame FIFO, then launches N frames (or runs continuously) with a programmable idle gap between frames.
- Reports progress, completion and faults to the host register bank.

Parameters:
WAIT_TIMEOUT, 1024, ti_clk cycles allowed in WAIT_DATA for the FIFO to reach one full frame before underrun is flagged.
ACK_TIMEOUT, 16, ti_clk cycles allowed after frame_go for frame_active to rise before ack_fault is flagged.

Ports:
ti_clk  in  1  system clock; all logic on the rising edge.
rst_n  in  1  asynchronous, active-low reset.
cfg_length  in  32  bytes per column (host register).
cfg_delay  in  32  columns per frame (host register).
cfg_frames  in  16  number of frames to run; 0 = continuous.
cfg_gap  in  16  idle ti_clk cycles between frame end and the next data check.
start  in  1  single-cycle run request.
abort  in  1  single-cycle stop request.
fifo_byte_level  in  16  bytes currently readable from the frame FIFO.
frame_active  in  1  FRAME output of Frame_State.
reg_length  out  32  shadowed length driven to Frame_State.
reg_delay  out  32  shadowed delay driven to Frame_State.
frame_go  out  1  single-cycle frame launch strobe to Frame_State.
busy  out  1  high whenever state ≠ IDLE.
done  out  1  single-cycle pulse when a run ends, for any reason.
seq_state  out  3  current state encoding, for debug.
frames_done  out  16  frames completed in the current or last run; wraps 0xFFFF→0.
underrun  out  1  sticky; cleared on an accepted start.
ack_fault  out  1  sticky; cleared on an accepted start.
cfg_error  out  1  sticky; cleared on an accepted start.

Behaviour:
- Reset values: all outputs 0; state IDLE; all counters and timers 0.
- State encodings: IDLE=0, ARM=1, WAIT_DATA=2, LAUNCH=3, RUN=4, GAP=5, DONE=6.
- IDLE, start with abort low:
  - If cfg_length=0 or cfg_delay=0: set cfg_error, stay in IDLE, do not assert busy.
  - Otherwise: latch reg_length, reg_delay, cfg_frames and cfg_gap; clear frames_done and all three fault flags; go to ARM.
- IDLE, start and abort in the same cycle: abort wins; nothing happens.
- ARM (exactly 1 cycle):
  - need = reg_length × reg_delay, computed as a 64-bit product and registered.
  - Go to WAIT_DATA.
- WAIT_DATA:
  - Compare zero-extended fifo_byte_level against need each cycle.
  - If fifo_byte_level ≥ need, go to LAUNCH; frame_go is high for exactly the first LAUNCH cycle.
  - Any need > 65535 can never be met and will time out.
  - After WAIT_TIMEOUT consecutive cycles without the condition, set underrun and go to DONE.
- LAUNCH:
  - When frame_active=1, go to RUN.
  - After ACK_TIMEOUT cycles without frame_active, set ack_fault and go to DONE.
- RUN:
  - Detect the falling edge of frame_active with a registered copy; on it, increment frames_done.
  - If cfg_frames≠0 and the new frames_done = cfg_frames, go to DONE.
  - Else if cfg_gap=0, go to WAIT_DATA; else go to GAP.
- GAP: count exactly cfg_gap cycles, then go to WAIT_DATA.
- DONE (1 cycle): done=1, then go to IDLE.
- Abort:
  - In ARM, WAIT_DATA or GAP: go to DONE on the next cycle.
  - In LAUNCH or RUN: set an internal abort_pending flag. The current frame always finishes and is never truncated at the DAC. At frame end, frames_done increments and the state goes to DONE.
  - Abort while in IDLE or DONE is ignored.
- start while busy is ignored.
- Changes to cfg_* during a run have no effect until the next accepted start.
- Reset asserted mid-run forces everything to reset values immediately; frame_go is never left asserted.
- Continuous mode (cfg_frames=0) ends only via abort or a fault.

Test Plan:
1. Length 8, delay 3, frames 2, gap 4; fifo_byte_level held at 30; frame_active high 24 cycles after each frame_go → exactly 2 frame_go pulses; second frame_go issued 4 GAP cycles plus 1 WAIT_DATA cycle after the first frame's end; frames_done=2; one done pulse; busy low afterwards.
2. Length 8, delay 3; fifo_byte_level=23 for 1024 cycles → no frame_go; underrun=1; done pulses; next start with level=24 clears underrun and launches.
3. Start with cfg_delay=0 → cfg_error=1, busy stays 0; a later valid start clears cfg_error.
4. Frames 0 (continuous); abort issued mid-frame → frame completes, frames_done increments, then done; no further frame_go.
5. frame_active never rises after frame_go → ack_fault=1 exactly 16 cycles later; state returns to IDLE.
6. rst_n pulsed low while in RUN → all outputs 0 asynchronously; cfg_length changed mid-run with no reset → reg_length unchanged until the next start.
